// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer sharing one fixed-latency 4-bit arithmetic unit between two requesters.
module alu_scheduler #(
  parameter int ARITH_LAT = 1,
  parameter int SHIFT_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_flag,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_lshift,
  output logic       alu_rshift,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  input  logic [3:0] alu_out,
  input  logic       alu_overflow,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic last, grant1, accept, sample;
  logic [1:0] op;
  logic [2:0] cnt;
  always_comb begin
    grant1 = req1_valid && (!req0_valid || !last);
    accept = reset && state == IDLE && (req0_valid || req1_valid);
    sample = state == WAIT && cnt == 3'd1;
    state_nx = state == IDLE  ? (accept ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (sample ? RESP : WAIT) :
                                (rsp_ready ? IDLE : RESP);
  end
  assign req0_ready = accept && !grant1;
  assign req1_ready = accept && grant1;
  assign busy       = state != IDLE;
  assign rsp_valid  = state == RESP;
  assign alu_add    = state == ISSUE && op == 2'd0;
  assign alu_sub    = state == ISSUE && op == 2'd1;
  assign alu_lshift = state == ISSUE && op == 2'd2;
  assign alu_rshift = state == ISSUE && op == 2'd3;
  // Operand registers double as the unit inputs, so they hold until the next acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      op       <= 2'd0;
      cnt      <= 3'd0;
      alu_in1  <= 4'd0;
      alu_in2  <= 4'd0;
      rsp_id   <= 1'b0;
      rsp_data <= 4'd0;
      rsp_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last    <= grant1;
        op      <= grant1 ? req1_op : req0_op;
        alu_in1 <= grant1 ? req1_a : req0_a;
        alu_in2 <= grant1 ? req1_b : req0_b;
      end
      if (state == ISSUE) cnt <= op[1] ? 3'(SHIFT_LAT) : 3'(ARITH_LAT);
      else if (state == WAIT) cnt <= cnt - 3'd1;
      if (sample) begin
        rsp_id   <= last;
        rsp_data <= alu_out;
        rsp_flag <= alu_overflow;
      end
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: scoreboard bench with a behavioural arithmetic unit and request/response model.
module tb_alu_scheduler;
  localparam int ARITH_LAT = 1;
  localparam int SHIFT_LAT = 2;
  logic clk = 0, reset = 0, rsp_ready = 1;
  logic v[2];
  logic [1:0] op[2];
  logic [3:0] a[2], b[2];
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_flag, busy;
  logic alu_add, alu_sub, alu_lshift, alu_rshift, alu_overflow;
  logic [3:0] rsp_data, alu_in1, alu_in2, alu_out;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  alu_scheduler #(.ARITH_LAT(ARITH_LAT), .SHIFT_LAT(SHIFT_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lshift(alu_lshift), .alu_rshift(alu_rshift),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_overflow(alu_overflow), .busy(busy)
  );

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  // {flag, data} of the arithmetic unit
  function automatic logic [4:0] f(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    case (o)
      2'd0: return {1'b0, x} + {1'b0, y};
      2'd1: return {x < y, 4'(x - y)};
      2'd2: return {x, 1'b0};
      default: return {x[0], 1'b0, x[3:1]};
    endcase
  endfunction

  // Unit model: result is valid only from LAT cycles after the strobe, inverted junk before that.
  logic [1:0] u_op = 0;
  int age = 99;
  assign {alu_overflow, alu_out} = f(u_op, alu_in1, alu_in2) ^
    ((age >= (u_op[1] ? SHIFT_LAT : ARITH_LAT)) ? 5'h00 : 5'h1f);
  initial forever begin
    @(posedge clk);
    if (alu_add | alu_sub | alu_lshift | alu_rshift) begin
      u_op <= {alu_lshift | alu_rshift, alu_sub | alu_rshift};
      age <= 1;
    end else if (age < 99) age <= age + 1;
  end

  typedef struct {logic id; logic [4:0] fd; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, iss_cyc = -10;
  logic [1:0] iss_op = 0;
  logic idle = 1, last = 1, prv_valid = 0, w1, any;
  logic [7:0] gbits = 0;
  logic [5:0] last_rsp = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      chk("reset_outputs", {busy, rsp_valid, rsp_id, rsp_data, rsp_flag, alu_add, alu_sub, alu_lshift,
          alu_rshift, alu_in1, alu_in2, req0_ready, req1_ready}, 0);
      q.delete();
      idle = 1; last = 1; prv_valid = 0; iss_cyc = -10;
    end else begin
      w1 = v[1] && (!v[0] || !last);
      any = v[0] || v[1];
      chk("ready", {req0_ready, req1_ready}, {idle && v[0] && !w1, idle && w1});
      chk("busy", busy, !idle);
      chk("strobes", {alu_add, alu_sub, alu_lshift, alu_rshift}, cyc == iss_cyc ? 4'b1000 >> iss_op : 4'b0);
      if (rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          if (!prv_valid) chk("rsp_time", cyc, q[0].due);
          chk("rsp", {rsp_id, rsp_flag, rsp_data}, {q[0].id, q[0].fd});
          if (rsp_ready) begin
            last_rsp = {rsp_id, rsp_flag, rsp_data};
            void'(q.pop_front());
          end
        end
      end
      if (idle && any) begin
        q.push_back('{w1, f(op[w1], a[w1], b[w1]), cyc + 2 + (op[w1][1] ? SHIFT_LAT : ARITH_LAT)});
        gbits = {gbits[6:0], req1_ready};
        last = w1; iss_cyc = cyc + 1; iss_op = op[w1]; idle = 0;
      end else if (rsp_valid && rsp_ready) idle = 1;
      prv_valid = rsp_valid;
    end
  end

  task automatic send(input int p, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                      input bit wd, output bit ok);
    int lim = wd ? int'($urandom_range(0, 3)) : 300;
    ok = 0;
    v[p] = 1; op[p] = o; a[p] = x; b[p] = y;
    for (int n = 0; n <= lim && !ok; n++) begin
      @(negedge clk);
      ok = (p == 1) ? req1_ready : req0_ready;
    end
    @(posedge clk); #1;
    v[p] = 0;
    if (!wd) chk("accept_timeout", ok, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (!(idle && q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_timeout", n < 200, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic rnd_port(input int p);
    bit ok;
    for (int i = 0; i < 40; i++) begin
      send(p, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0, ok);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  bit ok, rdone = 0;
  initial begin
    v[0] = 0; v[1] = 0; op[0] = 0; op[1] = 0; a[0] = 0; a[1] = 0; b[0] = 0; b[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    send(0, 2'd0, 4'h9, 4'h8, 0, ok);
    drain();
    chk("add_9_8", last_rsp, {1'b0, 1'b1, 4'h1});
    pulse_reset();
    fork
      send(0, 2'd1, 4'h3, 4'h5, 0, ok);
      send(1, 2'd0, 4'h2, 4'h2, 0, ok);
    join
    drain();
    chk("tie_order", gbits[1:0], 2'b01);
    chk("add_2_2", last_rsp, {1'b1, 1'b0, 4'h4});
    fork
      begin send(0, 2'd0, 4'h1, 4'h2, 0, ok); send(0, 2'd1, 4'h7, 4'h2, 0, ok); end
      begin send(1, 2'd3, 4'h9, 4'h0, 0, ok); send(1, 2'd2, 4'hc, 4'h0, 0, ok); end
    join
    drain();
    chk("alternate", gbits[3:0], 4'b0101);
    send(1, 2'd2, 4'b1010, 4'h0, 0, ok);
    drain();
    chk("lshift", last_rsp, {1'b1, 1'b1, 4'b0100});
    rsp_ready = 0;
    send(0, 2'd0, 4'hf, 4'h1, 0, ok);
    fork
      send(0, 2'd3, 4'h6, 4'h0, 0, ok);
      begin repeat (9) @(posedge clk); #1 rsp_ready = 1; end
    join
    drain();
    chk("rshift", last_rsp, {1'b0, 1'b0, 4'h3});
    send(0, 2'd2, 4'h5, 4'h0, 0, ok);
    @(posedge clk); #2 reset = 0;
    #1 chk("async_reset", {busy, alu_add, alu_sub, alu_lshift, alu_rshift, rsp_valid, alu_in1}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    send(1, 2'd0, 4'h7, 4'h7, 0, ok);
    drain();
    chk("after_reset", last_rsp, {1'b1, 1'b0, 4'he});
    fork
      while (!rdone) begin
        @(posedge clk); #1 rsp_ready = $urandom_range(0, 3) != 0;
      end
    join_none
    fork
      rnd_port(0);
      rnd_port(1);
    join
    rdone = 1;
    @(posedge clk); #1 rsp_ready = 1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and arbiter that shares the 4-bit arithmetic unit between two requesters. It accepts one operation at a time through a valid/ready handshake, arbitrating round-robin between ports 0 and 1. It drives the one-hot add/sub/lshift/rshift strobes and operands, waits the fixed unit latency, then captures the result and overflow flag. Results return on a single response channel tagged with the requester id.

## Interface
Parameters:
- ARITH_LAT, 1: cycles from strobe cycle to valid unit output for add/sub (legal 1-7).
- SHIFT_LAT, 2: cycles from strobe cycle to valid unit output for lshift/rshift (legal 1-7).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request pending on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  2  opcode: 00 add, 01 sub, 10 lshift, 11 rshift.
- req0_a, req0_b / req1_a, req1_b  in  4 each  operands (b ignored for shifts).
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  port that issued the response.
- rsp_data  out  4  captured unit result.
- rsp_flag  out  1  captured overflow/shift-out flag.
- alu_add, alu_sub, alu_lshift, alu_rshift  out  1 each  one-hot unit strobes.
- alu_in1, alu_in2  out  4 each  unit operands.
- alu_out  in  4  unit result.
- alu_overflow  in  1  unit flag.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any reqN_valid, pick a winner. reqN_ready is combinational: high only in IDLE for the winner. Latch op, a, b, and id. Go to ISSUE.
- Arbitration: single requester wins outright. If both are valid, the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie. The pointer updates only on acceptance.
- ISSUE (1 cycle): exactly one strobe is high, per the latched op. Load the counter with ARITH_LAT (op 00/01) or SHIFT_LAT (op 10/11). Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter equals 1, sample alu_out and alu_overflow into rsp_data and rsp_flag, set rsp_id, then go to RESP.
- RESP: rsp_valid is high. When rsp_valid and rsp_ready are both high, the next state is IDLE and rsp_valid drops.
- alu_in1 and alu_in2 drive the latched operands from ISSUE through the sample cycle. They hold their last value otherwise.
- Strobes are low in all states except ISSUE. Never more than one strobe is high.
- No new request is accepted outside IDLE. A requester must hold valid and payload stable until it sees ready.
- The counter is 3 bits. Latency values outside 1-7 are illegal and their behaviour is unspecified.

## Timing
- Reset (asynchronous, active-low) takes effect immediately, even mid-operation:
  - State goes to IDLE and the pointer to 1.
  - All outputs are 0: strobes, alu_in1/2, rsp_*, reqN_ready, busy.
  - The in-flight operation is dropped and produces no response.
- Handshake accepted in cycle T:
  - ISSUE in T+1.
  - Sample at the end of T+1+LAT.
  - rsp_valid high from T+2+LAT.
  - Add/sub with the default latency gives rsp_valid at T+3; shift gives T+4.
- Minimum spacing is one request per LAT+3 cycles, assuming rsp_ready is already high. The earliest next acceptance is the cycle after the response handshake.
- rsp_ready may be high before rsp_valid; the response then completes in its first cycle.
- A rsp_ready low stall holds rsp_id, rsp_data, and rsp_flag stable.
- A requester dropping valid before acceptance simply withdraws its request; no ready is issued.

## Test plan
- Reset then req0 add a=4'h9, b=4'h8 accepted at T:
  - alu_add high only at T+1.
  - rsp_valid at T+3 with id 0, data 4'h1, flag 1.
- Both ports valid in the same cycle after reset (req0 sub 3-5, req1 add 2+2):
  - Port 0 is served first: data 4'hE, flag 1.
  - Port 1 is served next: data 4'h4, flag 0.
  - With both held valid continuously, grants alternate 0,1,0,1.
- req1 lshift a=4'b1010, SHIFT_LAT=2:
  - alu_lshift high for one cycle, in1 held through the sample cycle.
  - rsp_valid at T+4 with data 4'b0100, flag 1.
- Hold rsp_ready low for 5 cycles while req0 stays valid:
  - rsp_* are stable and req0_ready stays 0.
  - Acceptance occurs the cycle after rsp_ready rises.
- Assert reset during WAIT:
  - busy and all strobes go to 0 immediately, and no rsp_valid appears.
  - The next request after release runs with normal latency.
- Random ops with a scoreboard:
  - At most one strobe is high at any time.
  - Each accepted request produces exactly one response.
  - rsp_id matches the issuing port.
